conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_pos_counter.sv | 64 ++++++
 rtl/conv_window_ctrl.sv | 134 +++++++++++++
 tb/tb_conv_window_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_pkg
// Brief  : Shared FSM state encoding and counter-width helpers for the
//          convolution window controller and its line-buffer datapath.
// Rev    : 1.0  initial release
// ============================================================================
package conv_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default image geometry, shared with the line-buffer datapath.
  localparam int unsigned DEF_IMG_W = 8;
  localparam int unsigned DEF_IMG_H = 8;
  localparam int unsigned DEF_K     = 3;

  // Counter width for a range of n values; a 1-entry range still needs 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_pos_counter.sv
`default_nettype none
// ============================================================================
// Module : conv_pos_counter
// Brief  : Raster-order column/row position counter. Column wraps at the
//          end of a line and bumps the row; last flags the final pixel.
// Rev    : 1.0  initial release
// ============================================================================
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  input  logic                      clr,
  output logic [cnt_w(IMG_W)-1:0]   col,
  output logic [cnt_w(IMG_H)-1:0]   row,
  output logic                      last
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Position registers; clr wins over inc so a restart always begins at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Next position: column wraps at line end, row wraps after the last line.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (inc) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : conv_window_ctrl
// Brief  : Sequencer for a KxK sliding-window convolution front end. Accepts
//          pixels in raster order, drives the line-buffer shift enable and
//          flags when a complete window sits in the datapath for the MAC.
// Rev    : 1.0  initial release
// ============================================================================
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned K     = DEF_K
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      sh_ce,
  input  logic                      out_ready,
  output logic                      win_valid,
  output logic [cnt_w(IMG_W)-1:0]   win_col,
  output logic [cnt_w(IMG_H)-1:0]   win_row,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  // First column/row at which the window is fully populated.
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  state_e        state_q, state_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          frame_done_q, frame_done_d;

  logic          accept;
  logic          win_load;
  logic          pos_clr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last;

  // Raster position of the next pixel to be accepted.
  conv_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (pos_clr),
    .col  (col),
    .row  (row),
    .last (last)
  );

  // A pixel may enter only while running and the window slot is free or draining.
  assign in_ready = (state_q == ST_RUN) && (!win_valid_q || out_ready);
  // Abort suppresses the accept so the datapath never shifts a cancelled pixel.
  assign accept   = in_valid && in_ready && !abort;
  assign sh_ce    = accept;
  assign win_load = accept && (col >= COL_FIRST) && (row >= ROW_FIRST);
  assign pos_clr  = abort || ((state_q == ST_IDLE) && start);

  // State, window and end-of-frame registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Frame sequencing; abort overrides every other event.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (accept && last) state_d = ST_DONE;
        ST_DONE: begin
          // Leave only once the final window has been taken downstream.
          if (!win_valid_q || out_ready) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Window handshake: a new complete window reloads, a consumed one clears.
  always_comb begin
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    if (abort) begin
      win_valid_d = 1'b0;
    end else if (win_load) begin
      win_valid_d = 1'b1;
      win_col_d   = col;
      win_row_d   = row;
    end else if (out_ready) begin
      win_valid_d = 1'b0;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_window_ctrl
// Brief  : Directed, table-driven bench for conv_window_ctrl on a 4x4 image
//          with a 3x3 kernel, plus hand-written reset sequence.
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_window_ctrl;

  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned K     = 3;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, out_ready;
  logic       in_ready, sh_ce, win_valid, busy, frame_done;
  logic [1:0] win_col, win_row;

  int n_cmp = 0;
  int n_bad = 0;

  // One cycle of stimulus and the outputs expected in that same cycle.
  typedef struct {
    logic       st, ab, iv, ordy;
    logic       ir, sh, wv;
    logic [1:0] wc, wr;
    logic       bsy, fd;
  } vec_t;

  vec_t vecs[$];

  conv_window_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sh_ce      (sh_ce),
    .out_ready  (out_ready),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic st, ab, iv, ordy, ir, sh, wv,
                     input logic [1:0] wc, wr, input logic bsy, fd);
    vec_t v;
    v.st = st; v.ab = ab; v.iv = iv; v.ordy = ordy;
    v.ir = ir; v.sh = sh; v.wv = wv; v.wc = wc; v.wr = wr;
    v.bsy = bsy; v.fd = fd;
    vecs.push_back(v);
  endtask

  // n plain accept cycles with no window present.
  task automatic add_acc(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0);
  endtask

  // Full back-to-back frame: start, 16 accepts, DONE, frame_done, idle.
  task automatic add_stream();
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // IDLE, start
    add_acc(11);                            // pixels 0..10
    add(0, 0, 1, 1, 1, 1, 1, 2, 2, 1, 0);   // pixel 11, window (2,2)
    add(0, 0, 1, 1, 1, 1, 1, 3, 2, 1, 0);   // pixel 12, window (3,2)
    add_acc(2);                             // pixels 13,14
    add(0, 0, 1, 1, 1, 1, 1, 2, 3, 1, 0);   // pixel 15, window (2,3)
    add(0, 0, 1, 1, 0, 0, 1, 3, 3, 1, 0);   // DONE, window (3,3)
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);   // IDLE, frame_done
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);   // IDLE, pulse over
  endtask

  // Drive just after the clock edge, check mid-cycle, then advance.
  task automatic apply_vec(input vec_t v, input string tag);
    start = v.st; abort = v.ab; in_valid = v.iv; out_ready = v.ordy;
    #2;
    check({tag, ".in_ready"},   {7'd0, in_ready},   {7'd0, v.ir});
    check({tag, ".sh_ce"},      {7'd0, sh_ce},      {7'd0, v.sh});
    check({tag, ".win_valid"},  {7'd0, win_valid},  {7'd0, v.wv});
    check({tag, ".busy"},       {7'd0, busy},       {7'd0, v.bsy});
    check({tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, v.fd});
    if (v.wv) begin
      check({tag, ".win_col"}, {6'd0, win_col}, {6'd0, v.wc});
      check({tag, ".win_row"}, {6'd0, win_row}, {6'd0, v.wr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag);
    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("%s[%0d]", tag, i));
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    // Reset state while rst is held.
    check("reset.busy",       {7'd0, busy},       8'd0);
    check("reset.in_ready",   {7'd0, in_ready},   8'd0);
    check("reset.sh_ce",      {7'd0, sh_ce},      8'd0);
    check("reset.win_valid",  {7'd0, win_valid},  8'd0);
    check("reset.frame_done", {7'd0, frame_done}, 8'd0);
    check("reset.win_col",    {6'd0, win_col},    8'd0);
    check("reset.win_row",    {6'd0, win_row},    8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back streaming frame.
    add_stream();
    run("stream");

    // Backpressure: downstream stalls 5 cycles on window (2,2).
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_acc(11);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 1, 2, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 1, 2, 2, 1, 0);   // pixel 11 accepted, (2,2) consumed
    add(0, 0, 1, 1, 1, 1, 1, 3, 2, 1, 0);   // pixel 12
    add_acc(2);                             // pixels 13,14
    add(0, 0, 1, 1, 1, 1, 1, 2, 3, 1, 0);   // pixel 15
    add(0, 0, 0, 1, 0, 0, 1, 3, 3, 1, 0);   // DONE
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);   // frame_done
    run("backpressure");

    // Abort after 6 accepts, then a clean restart.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_acc(6);
    add(0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0);   // abort: accept suppressed
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);   // IDLE, no frame_done
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    run("abort");
    add_stream();
    run("restart");

    // Illegal inputs: in_valid in IDLE, start pulsed in RUN.
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);   // start with in_valid in IDLE
    add_acc(3);                             // pixels 0..2
    add(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);   // start in RUN, no pixel
    add_acc(8);                             // pixels 3..10
    add(0, 0, 1, 1, 1, 1, 1, 2, 2, 1, 0);   // pixel 11
    add(0, 0, 1, 1, 1, 1, 1, 3, 2, 1, 0);   // pixel 12
    add_acc(2);                             // pixels 13,14
    add(0, 0, 1, 1, 1, 1, 1, 2, 3, 1, 0);   // pixel 15
    add(1, 0, 1, 1, 0, 0, 1, 3, 3, 1, 0);   // DONE ignores start and in_valid
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    run("illegal");

    // Stall in DONE on the last window.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_acc(11);
    add(0, 0, 1, 1, 1, 1, 1, 2, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 1, 3, 2, 1, 0);
    add_acc(2);
    add(0, 0, 1, 1, 1, 1, 1, 2, 3, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 3, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 3, 3, 1, 0);   // still DONE, window taken now
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);   // frame_done
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    run("done_stall");

    // Asynchronous reset mid-frame with window (2,2) present.
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_acc(11);
    run("pre_reset");
    start = 1'b0; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #2;
    check("midrst.win_valid_before", {7'd0, win_valid}, 8'd1);
    rst = 1'b1;
    #1;
    check("midrst.busy",       {7'd0, busy},       8'd0);
    check("midrst.in_ready",   {7'd0, in_ready},   8'd0);
    check("midrst.sh_ce",      {7'd0, sh_ce},      8'd0);
    check("midrst.win_valid",  {7'd0, win_valid},  8'd0);
    check("midrst.win_col",    {6'd0, win_col},    8'd0);
    check("midrst.win_row",    {6'd0, win_row},    8'd0);
    check("midrst.frame_done", {7'd0, frame_done}, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("postrst[%0d].busy", i),       {7'd0, busy},       8'd0);
      check($sformatf("postrst[%0d].sh_ce", i),      {7'd0, sh_ce},      8'd0);
      check($sformatf("postrst[%0d].frame_done", i), {7'd0, frame_done}, 8'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    add_stream();
    run("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
